// File: rtl/seq_alu.sv
`default_nettype none
// ============================================================================
//  Module   : seq_alu
//  Purpose  : Multi-cycle ALU for the EX stage. Single-cycle logic/arith ops
//             plus iterative unsigned MUL (shift-add) and DIVU (restoring)
//             behind a valid/ready handshake. Results are registered and
//             held until the next operation completes.
//  Options  : define SEQ_ALU_FLAGS_EN to add registered Carry/Overflow outputs.
//  Revision : 1.0  initial release
// ============================================================================
module seq_alu #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       ALUControl,
  output logic             out_valid,
  output logic [WIDTH-1:0] ALUOut,
  output logic [WIDTH-1:0] ALUOutHi,
  output logic             Zero,
  output logic             DivByZero
`ifdef SEQ_ALU_FLAGS_EN
  ,
  output logic             Carry,
  output logic             Overflow
`endif
);

  localparam int             c_cnt_w  = $clog2(WIDTH) + 1;
  localparam int             c_msb    = WIDTH - 1;
  localparam logic [c_cnt_w-1:0] c_last   = c_cnt_w'(WIDTH - 1);
  localparam logic [c_cnt_w-1:0] c_cnt_one = c_cnt_w'(1);

  localparam logic [3:0] c_op_and  = 4'b0000;
  localparam logic [3:0] c_op_or   = 4'b0001;
  localparam logic [3:0] c_op_add  = 4'b0010;
  localparam logic [3:0] c_op_sub  = 4'b0110;
  localparam logic [3:0] c_op_slt  = 4'b0111;
  localparam logic [3:0] c_op_nor  = 4'b1100;
  localparam logic [3:0] c_op_xor  = 4'b1101;
  localparam logic [3:0] c_op_mul  = 4'b1000;
  localparam logic [3:0] c_op_divu = 4'b1001;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DONE = 2'd1,
    ST_MUL  = 2'd2,
    ST_DIV  = 2'd3
  } state_t;

  state_t             r_state;
  logic [c_cnt_w-1:0] r_cnt;
  logic [WIDTH-1:0]   r_opd;   // multiplicand for MUL, divisor for DIVU
  logic [WIDTH-1:0]   r_hi;    // partial product high half / partial remainder
  logic [WIDTH-1:0]   r_lo;    // multiplier -> product low / dividend -> quotient

  logic               w_accept;
  logic               w_last;
  logic [WIDTH-1:0]   w_add;
  logic [WIDTH-1:0]   w_sub;
  logic [WIDTH-1:0]   w_sc_res;

  logic [WIDTH:0]     w_mul_sum;
  logic [WIDTH-1:0]   w_mul_hi;
  logic [WIDTH-1:0]   w_mul_lo;

  logic [WIDTH:0]     w_div_shift;
  logic               w_div_ok;
  logic [WIDTH-1:0]   w_div_sub;
  logic [WIDTH-1:0]   w_div_hi;
  logic [WIDTH-1:0]   w_div_lo;

  logic               w_load;
  logic [WIDTH-1:0]   w_nxt_lo;
  logic [WIDTH-1:0]   w_nxt_hi;
  logic               w_nxt_dbz;

  assign in_ready  = (r_state == ST_IDLE);
  assign out_valid = (r_state == ST_DONE);
  assign w_accept  = in_valid && (r_state == ST_IDLE);
  assign w_last    = (r_cnt == c_last);

  assign w_add = A + B;
  assign w_sub = A - B;

  // Single-cycle result, computed straight from the inputs on the accept cycle
  always_comb begin
    w_sc_res = '0;
    case (ALUControl)
      c_op_and: w_sc_res = A & B;
      c_op_or:  w_sc_res = A | B;
      c_op_add: w_sc_res = w_add;
      c_op_sub: w_sc_res = w_sub;
      c_op_slt: w_sc_res = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
      c_op_nor: w_sc_res = ~(A | B);
      c_op_xor: w_sc_res = A ^ B;
      default:  w_sc_res = '0;
    endcase
  end

  // One shift-add step: add multiplicand if multiplier LSB set, shift {carry,hi,lo} right
  assign w_mul_sum = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_opd} : '0);
  assign w_mul_hi  = w_mul_sum[WIDTH:1];
  assign w_mul_lo  = {w_mul_sum[0], r_lo[WIDTH-1:1]};

  // One restoring-division step: shift next dividend bit into remainder, try subtract.
  // When the subtract succeeds the difference is below the divisor, so WIDTH bits suffice.
  assign w_div_shift = {r_hi, r_lo[WIDTH-1]};
  assign w_div_ok    = (w_div_shift >= {1'b0, r_opd});
  assign w_div_sub   = w_div_shift[WIDTH-1:0] - r_opd;
  assign w_div_hi    = w_div_ok ? w_div_sub : w_div_shift[WIDTH-1:0];
  assign w_div_lo    = {r_lo[WIDTH-2:0], w_div_ok};

`ifdef SEQ_ALU_FLAGS_EN
  logic w_sc_c;
  logic w_sc_v;
  logic w_nxt_c;
  logic w_nxt_v;
  logic r_carry;
  logic r_ovf;

  // Flags for single-cycle ops; add carry-out recovered from the MSB column
  always_comb begin
    w_sc_c = 1'b0;
    w_sc_v = 1'b0;
    case (ALUControl)
      c_op_add: begin
        w_sc_c = (A[c_msb] & B[c_msb]) | ((A[c_msb] ^ B[c_msb]) & ~w_add[c_msb]);
        w_sc_v = (A[c_msb] == B[c_msb]) && (w_add[c_msb] != A[c_msb]);
      end
      c_op_sub: begin
        w_sc_c = (A < B);
        w_sc_v = (A[c_msb] != B[c_msb]) && (w_sub[c_msb] != A[c_msb]);
      end
      default: begin
        w_sc_c = 1'b0;
        w_sc_v = 1'b0;
      end
    endcase
  end
`endif

  // Select what gets captured into the result registers on entry to DONE
  always_comb begin
    w_load    = 1'b0;
    w_nxt_lo  = w_sc_res;
    w_nxt_hi  = '0;
    w_nxt_dbz = 1'b0;
`ifdef SEQ_ALU_FLAGS_EN
    w_nxt_c   = w_sc_c;
    w_nxt_v   = w_sc_v;
`endif
    case (r_state)
      ST_IDLE: begin
        if (w_accept && (ALUControl != c_op_mul) &&
            !((ALUControl == c_op_divu) && (B != '0))) begin
          w_load = 1'b1;
          if (ALUControl == c_op_divu) begin
            w_nxt_lo  = '1;
            w_nxt_hi  = A;
            w_nxt_dbz = 1'b1;
          end
        end
      end
      ST_MUL: begin
        if (w_last) begin
          w_load   = 1'b1;
          w_nxt_lo = w_mul_lo;
          w_nxt_hi = w_mul_hi;
`ifdef SEQ_ALU_FLAGS_EN
          w_nxt_c  = (w_mul_hi != '0);
          w_nxt_v  = (w_mul_hi != '0);
`endif
        end
      end
      ST_DIV: begin
        if (w_last) begin
          w_load   = 1'b1;
          w_nxt_lo = w_div_lo;
          w_nxt_hi = w_div_hi;
`ifdef SEQ_ALU_FLAGS_EN
          w_nxt_c  = 1'b0;
          w_nxt_v  = 1'b0;
`endif
        end
      end
      default: w_load = 1'b0;
    endcase
  end

  // Control FSM and iteration datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_opd   <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_cnt <= '0;
            r_hi  <= '0;
            if (ALUControl == c_op_mul) begin
              r_opd   <= A;
              r_lo    <= B;
              r_state <= ST_MUL;
            end else if (ALUControl == c_op_divu) begin
              r_opd   <= B;
              r_lo    <= A;
              r_state <= (B == '0) ? ST_DONE : ST_DIV;
            end else begin
              r_state <= ST_DONE;
            end
          end
        end
        ST_MUL: begin
          r_hi  <= w_mul_hi;
          r_lo  <= w_mul_lo;
          r_cnt <= r_cnt + c_cnt_one;
          if (w_last) r_state <= ST_DONE;
        end
        ST_DIV: begin
          r_hi  <= w_div_hi;
          r_lo  <= w_div_lo;
          r_cnt <= r_cnt + c_cnt_one;
          if (w_last) r_state <= ST_DONE;
        end
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Result registers: loaded once per operation, held otherwise
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ALUOut    <= '0;
      ALUOutHi  <= '0;
      Zero      <= 1'b1;
      DivByZero <= 1'b0;
    end else if (w_load) begin
      ALUOut    <= w_nxt_lo;
      ALUOutHi  <= w_nxt_hi;
      Zero      <= (w_nxt_lo == '0);
      DivByZero <= w_nxt_dbz;
    end
  end

`ifdef SEQ_ALU_FLAGS_EN
  // Status flags, captured alongside the results
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_carry <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (w_load) begin
      r_carry <= w_nxt_c;
      r_ovf   <= w_nxt_v;
    end
  end

  assign Carry    = r_carry;
  assign Overflow = r_ovf;
`else
  // Flag outputs are not present in this build; no flag state exists.
`endif

endmodule
`default_nettype wire

// File: tb/tb_seq_alu.sv
`default_nettype none
// ============================================================================
//  Module   : tb_seq_alu
//  Purpose  : Scoreboard bench for seq_alu. Stimulus pushes expected results
//             from an arithmetic reference model; a monitor pops and compares
//             on every out_valid and checks result hold between operations.
//  Revision : 1.0  initial release
// ============================================================================
module tb_seq_alu;

  localparam int W = 16;
  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_NOR  = 4'b1100;
  localparam logic [3:0] OP_XOR  = 4'b1101;
  localparam logic [3:0] OP_MUL  = 4'b1000;
  localparam logic [3:0] OP_DIVU = 4'b1001;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic [3:0]   ctrl = '0;
  logic         out_valid;
  logic [W-1:0] alu_out;
  logic [W-1:0] alu_hi;
  logic         zero;
  logic         dbz;
`ifdef SEQ_ALU_FLAGS_EN
  logic         carry;
  logic         ovf;
  logic         carry8;
  logic         ovf8;
`endif

  logic         in_valid8 = 1'b0;
  logic         in_ready8;
  logic [7:0]   a8 = '0;
  logic [7:0]   b8 = '0;
  logic [3:0]   ctrl8 = '0;
  logic         out_valid8;
  logic [7:0]   alu_out8;
  logic [7:0]   alu_hi8;
  logic         zero8;
  logic         dbz8;

  seq_alu #(.WIDTH(W)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .A(a), .B(b), .ALUControl(ctrl), .out_valid(out_valid),
    .ALUOut(alu_out), .ALUOutHi(alu_hi), .Zero(zero), .DivByZero(dbz)
`ifdef SEQ_ALU_FLAGS_EN
    , .Carry(carry), .Overflow(ovf)
`endif
  );

  seq_alu #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
    .A(a8), .B(b8), .ALUControl(ctrl8), .out_valid(out_valid8),
    .ALUOut(alu_out8), .ALUOutHi(alu_hi8), .Zero(zero8), .DivByZero(dbz8)
`ifdef SEQ_ALU_FLAGS_EN
    , .Carry(carry8), .Overflow(ovf8)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct {
    logic [W-1:0] lo;
    logic [W-1:0] hi;
    logic         dbz;
    logic         c;
    logic         v;
    int           lat;
    int           exp_cyc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  logic [W-1:0] hold_lo  = '0;
  logic [W-1:0] hold_hi  = '0;
  logic         hold_z   = 1'b1;
  logic         hold_dbz = 1'b0;

  function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, req, $time);
    end
  endfunction

  // Reference model: results from plain integer arithmetic
  function automatic exp_t model(input logic [3:0] op, input logic [W-1:0] xa, input logic [W-1:0] xb);
    exp_t         e;
    int           sa;
    int           sb_;
    int           ua;
    int           ub;
    logic [2*W-1:0] p;
    e = '{lo: '0, hi: '0, dbz: 1'b0, c: 1'b0, v: 1'b0, lat: 1, exp_cyc: 0};
    sa  = $signed(xa);
    sb_ = $signed(xb);
    ua  = int'(xa);
    ub  = int'(xb);
    case (op)
      OP_AND: e.lo = xa & xb;
      OP_OR:  e.lo = xa | xb;
      OP_NOR: e.lo = ~(xa | xb);
      OP_XOR: e.lo = xa ^ xb;
      OP_ADD: begin
        e.lo = W'(ua + ub);
        e.c  = (ua + ub) >= (1 << W);
        e.v  = ((sa + sb_) > 32767) || ((sa + sb_) < -32768);
      end
      OP_SUB: begin
        e.lo = W'(ua - ub);
        e.c  = ua < ub;
        e.v  = ((sa - sb_) > 32767) || ((sa - sb_) < -32768);
      end
      OP_SLT: e.lo = (sa < sb_) ? W'(1) : W'(0);
      OP_MUL: begin
        p     = {{W{1'b0}}, xa} * {{W{1'b0}}, xb};
        e.lo  = p[W-1:0];
        e.hi  = p[2*W-1:W];
        e.c   = (e.hi != '0);
        e.v   = (e.hi != '0);
        e.lat = W + 1;
      end
      OP_DIVU: begin
        if (xb == '0) begin
          e.lo  = '1;
          e.hi  = xa;
          e.dbz = 1'b1;
        end else begin
          e.lo  = xa / xb;
          e.hi  = xa % xb;
          e.lat = W + 1;
        end
      end
      default: e.lo = '0;
    endcase
    return e;
  endfunction

  // Issue one operation (call on a negedge); returns the accept cycle
  task automatic issue(input logic [3:0] op, input logic [W-1:0] xa, input logic [W-1:0] xb, output int acc);
    int   guard;
    exp_t e;
    guard = 0;
    while (!in_ready && guard < 64) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready) begin
      chk("in_ready_timeout", {63'b0, in_ready}, 64'd1);
      acc = -1;
      return;
    end
    e = model(op, xa, xb);
    e.exp_cyc = cyc + e.lat;
    ctrl = op;
    a = xa;
    b = xb;
    in_valid = 1'b1;
    sb.push_back(e);
    acc = cyc;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Monitor: compare each output pulse against the scoreboard; check hold otherwise
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid) begin
        if (sb.size() == 0) begin
          chk("unexpected_out_valid", {63'b0, out_valid}, 64'd0);
        end else begin
          mon_e = sb.pop_front();
          chk("latency_cycle", 64'(cyc), 64'(mon_e.exp_cyc));
          chk("ALUOut", 64'(alu_out), 64'(mon_e.lo));
          chk("ALUOutHi", 64'(alu_hi), 64'(mon_e.hi));
          chk("Zero", {63'b0, zero}, {63'b0, (mon_e.lo == '0)});
          chk("DivByZero", {63'b0, dbz}, {63'b0, mon_e.dbz});
`ifdef SEQ_ALU_FLAGS_EN
          chk("Carry", {63'b0, carry}, {63'b0, mon_e.c});
          chk("Overflow", {63'b0, ovf}, {63'b0, mon_e.v});
`endif
          hold_lo  = mon_e.lo;
          hold_hi  = mon_e.hi;
          hold_z   = (mon_e.lo == '0);
          hold_dbz = mon_e.dbz;
        end
      end else begin
        chk("hold_ALUOut", 64'(alu_out), 64'(hold_lo));
        chk("hold_ALUOutHi", 64'(alu_hi), 64'(hold_hi));
        chk("hold_Zero", {63'b0, zero}, {63'b0, hold_z});
        chk("hold_DivByZero", {63'b0, dbz}, {63'b0, hold_dbz});
      end
    end
  end

  logic [3:0] ops [9] = '{OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT, OP_NOR, OP_XOR, OP_MUL, OP_DIVU};

  function automatic logic [W-1:0] pick_operand();
    case ($urandom_range(0, 4))
      0:       return '0;
      1:       return '1;
      2:       return W'($urandom_range(0, 15));
      3:       return {1'b1, W'($urandom) >> 1};
      default: return W'($urandom);
    endcase
  endfunction

  initial begin
    int         acc;
    int         c1;
    int         c2;
    int         n;
    int         c0;
    logic [3:0] op;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", {63'b0, in_ready}, 64'd1);
    chk("rst_out_valid", {63'b0, out_valid}, 64'd0);
    chk("rst_ALUOut", 64'(alu_out), 64'd0);
    chk("rst_ALUOutHi", 64'(alu_hi), 64'd0);
    chk("rst_Zero", {63'b0, zero}, 64'd1);
    chk("rst_DivByZero", {63'b0, dbz}, 64'd0);
`ifdef SEQ_ALU_FLAGS_EN
    chk("rst_Carry", {63'b0, carry}, 64'd0);
    chk("rst_Overflow", {63'b0, ovf}, 64'd0);
`endif
    @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);

    // Reset in the middle of a MUL: operation is lost
    ctrl = OP_MUL;
    a = 16'h1234;
    b = 16'h0003;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", {63'b0, out_valid}, 64'd0);
    chk("midrst_ALUOut", 64'(alu_out), 64'd0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_in_ready", {63'b0, in_ready}, 64'd1);
    chk("midrst_out_valid_after", {63'b0, out_valid}, 64'd0);
    chk("midrst_ALUOut_after", 64'(alu_out), 64'd0);
    chk("midrst_Zero_after", {63'b0, zero}, 64'd1);

    // Directed corner cases
    issue(OP_ADD, 16'hFFFF, 16'h0001, acc);
    issue(OP_SLT, 16'hFFFF, 16'h0001, acc);
    issue(OP_SLT, 16'h0003, 16'h0002, acc);
    issue(OP_SUB, 16'h8000, 16'h0001, acc);

    // MUL busy window; an op offered while busy must be dropped
    issue(OP_MUL, 16'hFFFF, 16'hFFFF, acc);
    n = 0;
    while (!in_ready && n < 40) begin
      n++;
      if (n == 3) begin
        ctrl = OP_ADD;
        a = 16'h0001;
        b = 16'h0001;
        in_valid = 1'b1;
      end
      if (n == 4) in_valid = 1'b0;
      @(negedge clk);
    end
    in_valid = 1'b0;
    chk("mul_busy_cycles", 64'(n), 64'd17);

    issue(OP_DIVU, 16'h0064, 16'h0007, acc);
    issue(OP_DIVU, 16'h1234, 16'h0000, acc);
    issue(OP_AND, 16'hAAAA, 16'h5555, c1);
    issue(OP_OR, 16'hAAAA, 16'h5555, c2);
    chk("back_to_back_gap", 64'(c2 - c1), 64'd2);
    issue(4'b0011, 16'h1234, 16'h5678, acc);

    // Randomized traffic
    for (int i = 0; i < 80; i++) begin
      op = ops[$urandom_range(0, 8)];
      if ($urandom_range(0, 9) == 0) op = 4'($urandom_range(0, 15));
      issue(op, pick_operand(), pick_operand(), acc);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    // WIDTH=8 instance: MUL latency WIDTH+1
    n = 0;
    while (!in_ready8 && n < 40) begin
      @(negedge clk);
      n++;
    end
    ctrl8 = OP_MUL;
    a8 = 8'hFF;
    b8 = 8'hFF;
    in_valid8 = 1'b1;
    c0 = cyc;
    @(negedge clk);
    in_valid8 = 1'b0;
    while (!out_valid8 && (cyc - c0) < 40) @(negedge clk);
    chk("w8_mul_latency", 64'(cyc - c0), 64'd9);
    chk("w8_mul_lo", 64'(alu_out8), 64'h01);
    chk("w8_mul_hi", 64'(alu_hi8), 64'hFE);

    // Drain the scoreboard
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("scoreboard_drained", 64'(sb.size()), 64'd0);
    repeat (3) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
